sseg4_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a 4-digit common-anode seven-segment display. It holds a double-buffered 16-bit BCD value and selects one digit at a time on a single shared BCD-to-seven-segment decoder. It drives the active-low anode lines and the decimal point, and inserts a guard interval between digits to prevent ghosting. It sits between the application logic, which loads values through a ready/load handshake, and the decoder/pin level.

---
 rtl/sseg4_scan_ctrl.sv | 101 ++++++++++
 tb/tb_sseg4_scan_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg4_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Double-buffered BCD value, per-slot guard blanking, leading-zero suppression.
module sseg4_scan_ctrl #(
  parameter int unsigned DIV   = 100000,
  parameter int unsigned GUARD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic        ready,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        dp_n
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          boundary;

  logic [15:0]   pend_bcd;
  logic [3:0]    pend_dp;
  logic          pend_vld;
  logic [15:0]   disp_bcd;
  logic [3:0]    disp_dp;

  logic [3:0]    blank;
  logic          lit;
  logic [3:0]    an_nxt;
  logic [3:0]    bcd_nxt;
  logic          dp_n_nxt;

  assign ready    = ~pend_vld;
  assign boundary = (idx == 2'd3) && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Load is only accepted while pending is empty, so it can never collide
  // with a transfer in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_bcd <= '0;
      pend_dp  <= '0;
      pend_vld <= 1'b0;
      disp_bcd <= '0;
      disp_dp  <= '0;
    end else begin
      if (load && !pend_vld) begin
        pend_bcd <= bcd_in;
        pend_dp  <= dp_in;
        pend_vld <= 1'b1;
      end else if (boundary && pend_vld) begin
        disp_bcd <= pend_bcd;
        disp_dp  <= pend_dp;
        pend_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    blank    = '0;
    blank[3] = lz_en && (disp_bcd[15:12] == 4'h0);
    blank[2] = lz_en && (disp_bcd[15:8]  == 8'h00);
    blank[1] = lz_en && (disp_bcd[15:4]  == 12'h000);
  end

  always_comb begin
    lit      = (cnt >= CW'(GUARD)) && !blank[idx];
    an_nxt   = '1;
    an_nxt[idx] = ~lit;
    bcd_nxt  = disp_bcd[idx*4 +: 4];
    dp_n_nxt = lit ? ~disp_dp[idx] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= '1;
      bcd  <= '0;
      dp_n <= 1'b1;
    end else begin
      an   <= an_nxt;
      bcd  <= bcd_nxt;
      dp_n <= dp_n_nxt;
    end
  end

endmodule

// File: tb/tb_sseg4_scan_ctrl.sv
// Randomised scoreboard bench for sseg4_scan_ctrl (DIV=8, GUARD=2).
module tb_sseg4_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        ready;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp_n;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic       dp_n;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int          m_t;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic        m_pvld;

  sseg4_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .bcd_in (bcd_in),
    .dp_in  (dp_in),
    .lz_en  (lz_en),
    .ready  (ready),
    .bcd    (bcd),
    .an     (an),
    .dp_n   (dp_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Model: slot and position come straight from elapsed cycles since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_pend = '0; m_disp = '0; m_pdp = '0; m_ddp = '0; m_pvld = 1'b0;
      exp_q.delete();
    end else begin
      int   slot, pos;
      logic blanked, lit;
      exp_t e;
      slot    = (m_t / DIV) % 4;
      pos     = m_t % DIV;
      blanked = lz_en && (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0);
      lit     = (pos >= GUARD) && !blanked;
      e.an    = lit ? ~(4'b0001 << slot) : 4'b1111;
      e.bcd   = 4'((m_disp >> (4 * slot)) & 16'hF);
      e.dp_n  = lit ? ~m_ddp[slot] : 1'b1;
      if ((m_t % (4 * DIV)) == (4 * DIV - 1) && m_pvld) begin
        m_disp = m_pend; m_ddp = m_pdp; m_pvld = 1'b0;
      end else if (load && !m_pvld) begin
        m_pend = bcd_in; m_pdp = dp_in; m_pvld = 1'b1;
      end
      e.ready = !m_pvld;
      m_t++;
      exp_q.push_back(e);
    end
  end

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if ({an, bcd, dp_n, ready} !== e) begin
        errors++;
        $display("FAIL scan t=%0t: an=%b bcd=%h dp_n=%b ready=%b expected an=%b bcd=%h dp_n=%b ready=%b",
                 $time, an, bcd, dp_n, ready, e.an, e.bcd, e.dp_n, e.ready);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 5 * DIV) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL ready_timeout: ready=%b expected 1", ready);
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    bcd_in = v; dp_in = d; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bcd_in = $urandom; dp_in = $urandom;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd_in = '0; dp_in = '0; lz_en = 1'b0;
    cycles(3);
    check("rst_an", 32'(an), 32'hF);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_dp_n", 32'(dp_n), 32'h1);
    check("rst_ready", 32'(ready), 32'h1);
    rst_n = 1'b1;
    cycles(4 * DIV + 4);

    // 0x1234, no dp, no suppression
    pulse_load(16'h1234, 4'h0);
    check("ready_low_after_load", 32'(ready), 32'h0);
    cycles(8 * DIV);

    // leading zeros
    lz_en = 1'b1;
    wait_ready();
    pulse_load(16'h0045, 4'h0);
    cycles(8 * DIV);
    wait_ready();
    pulse_load(16'h0000, 4'hF);
    cycles(8 * DIV);

    // second load while busy is dropped
    lz_en = 1'b0;
    wait_ready();
    pulse_load(16'h1111, 4'h0);
    @(negedge clk);
    pulse_load(16'h2222, 4'hF);
    cycles(8 * DIV);

    // decimal point on digit 2
    wait_ready();
    pulse_load(16'h5678, 4'b0100);
    cycles(8 * DIV);

    // randomised loads, lz_en toggles, nibbles above 9
    for (int i = 0; i < 40; i++) begin
      cycles($urandom_range(0, 3 * DIV));
      if ($urandom_range(0, 3) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 1) == 0)
        pulse_load(16'($urandom) & 16'h0F0F, 4'($urandom));
      else
        pulse_load(16'($urandom), 4'($urandom));
    end
    cycles(8 * DIV);

    // asynchronous reset mid-slot with a pending load
    lz_en = 1'b0;
    wait_ready();
    pulse_load(16'h9ABC, 4'b0100);
    begin
      int k = 0;
      while (!(an == 4'b1011 && !ready) && k < 8 * DIV) begin
        @(negedge clk);
        k++;
      end
      checks++;
      if (!(an == 4'b1011 && !ready)) begin
        errors++;
        $display("FAIL reset_setup: an=%b ready=%b expected an=1011 ready=0", an, ready);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_ready", 32'(ready), 32'h1);
    check("async_rst_bcd", 32'(bcd), 32'h0);
    check("async_rst_dp_n", 32'(dp_n), 32'h1);
    cycles(2);
    #1 rst_n = 1'b1;
    cycles(8 * DIV + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
